// File: rtl/gp_arb_pkg.sv
// Shared types and helpers for the GP read/write arbiter: FSM state
// encoding, round-robin pointer values and width helpers.
package gp_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } arbState_t;

    localparam logic GRANT_WR = 1'b1;
    localparam logic GRANT_RD = 1'b0;

    function automatic int addrLsb(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

    // Always at least one bit so a disabled timeout still elaborates.
    function automatic int cntWidth(input int timeoutCycles);
        return (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
    endfunction

endpackage

// File: rtl/gp_rr_arbiter2.sv
// Two-requester round-robin grant; the pointer favours the side that was
// not served by the most recent grant.
module gp_rr_arbiter2
    import gp_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_wr,
    input  logic req_rd,
    input  logic advance,
    output logic grant_wr,
    output logic grant_rd
);

    logic r_ptr;

    assign grant_wr = req_wr & (~req_rd | (r_ptr == GRANT_WR));
    assign grant_rd = req_rd & (~req_wr | (r_ptr == GRANT_RD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= GRANT_WR;
        end else if (advance && (grant_wr || grant_rd)) begin
            r_ptr <= grant_wr ? GRANT_RD : GRANT_WR;
        end
    end

endmodule

// File: rtl/gp_rw_arbiter.sv
// Sequences GP write/read requests onto a single-port word backend with
// address range checking, a backend timeout and done/error reporting.
module gp_rw_arbiter
    import gp_arb_pkg::*;
#(
    parameter int GP_ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                          s_axi_aclk,
    input  logic                                          s_axi_aresetn,
    input  logic                                          write,
    input  logic [GP_ADDR_WIDTH-1:0]                      write_addrs,
    input  logic [DATA_WIDTH-1:0]                         write_data,
    input  logic [DATA_WIDTH/8-1:0]                       write_strobe,
    output logic                                          write_done,
    output logic                                          write_error,
    input  logic                                          read,
    input  logic [GP_ADDR_WIDTH-1:0]                      read_addrs,
    output logic [DATA_WIDTH-1:0]                         read_data,
    output logic                                          read_done,
    output logic                                          read_error,
    output logic                                          mem_req,
    output logic                                          mem_we,
    output logic [GP_ADDR_WIDTH-addrLsb(DATA_WIDTH)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]                         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                       mem_wstrb,
    input  logic                                          mem_ack,
    input  logic [DATA_WIDTH-1:0]                         mem_rdata,
    input  logic                                          mem_err,
    output logic                                          busy
);

    localparam int ADDR_LSB = addrLsb(DATA_WIDTH);
    localparam int IDX_W    = GP_ADDR_WIDTH - ADDR_LSB;
    localparam int CNT_W    = cntWidth(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    arbState_t r_state;
    arbState_t w_nextState;

    logic                     r_isWrite;
    logic                     r_err;
    logic [CNT_W-1:0]         r_cnt;
    logic                     w_grantWr;
    logic                     w_grantRd;
    logic                     w_grant;
    logic                     w_advance;
    logic [GP_ADDR_WIDTH-1:0] w_selAddr;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_badAddr;
    logic                     w_zeroStrb;
    logic                     w_timeout;
    logic                     w_inDone;

    assign w_advance = (r_state == S_IDLE);

    gp_rr_arbiter2 u_rr (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .req_wr   (write),
        .req_rd   (read),
        .advance  (w_advance),
        .grant_wr (w_grantWr),
        .grant_rd (w_grantRd)
    );

    assign w_grant    = w_grantWr | w_grantRd;
    assign w_selAddr  = w_grantWr ? write_addrs : read_addrs;
    assign w_idx      = w_selAddr[GP_ADDR_WIDTH-1:ADDR_LSB];
    assign w_badAddr  = (32'(w_idx) >= 32'(MEM_DEPTH));
    assign w_zeroStrb = w_grantWr && (write_strobe == '0);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Rejected grants (bad address, empty write strobe) skip the backend.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_nextState = (w_badAddr || w_zeroStrb) ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_isWrite <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_isWrite <= w_grantWr;
                        r_err     <= w_badAddr;
                        r_cnt     <= '0;
                        mem_we    <= w_grantWr;
                        mem_addr  <= w_idx;
                        mem_wdata <= w_grantWr ? write_data : '0;
                        mem_wstrb <= w_grantWr ? write_strobe : '0;
                    end
                end
                S_ACCESS: begin
                    // An ack on the timeout cycle still completes normally.
                    if (mem_ack) begin
                        r_err <= mem_err;
                        if (!r_isWrite) begin
                            read_data <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_inDone    = (r_state == S_DONE);
    assign mem_req     = (r_state == S_ACCESS);
    assign busy        = (r_state != S_IDLE);
    assign write_done  = w_inDone & r_isWrite;
    assign write_error = write_done & r_err;
    assign read_done   = w_inDone & ~r_isWrite;
    assign read_error  = read_done & r_err;

endmodule

// File: doc/gp_rw_arbiter.md
Name: gp_rw_arbiter

Overview:
Sequencer between the AXI-lite slave's GP interface (independent write and read channels) and a single-port word-addressed backend such as a register bank or BRAM. Arbitrates simultaneous GP write/read requests round-robin and runs one backend access at a time. Range-checks addresses, applies a backend timeout, and returns done/error/data in the GP handshake the slave expects.

Parameters:
GP_ADDR_WIDTH, 6, GP byte-address width
DATA_WIDTH, 32, data width (multiple of 8); ADDR_LSB = clog2(DATA_WIDTH/8)
MEM_DEPTH, 16, backend words; word index >= MEM_DEPTH is an error
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack; 0 disables timeout

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
write  in  1  GP write request, held until write_done
write_addrs  in  GP_ADDR_WIDTH  GP write byte address
write_data  in  DATA_WIDTH  GP write data
write_strobe  in  DATA_WIDTH/8  GP byte enables
write_done  out  1  one-cycle pulse: write finished
write_error  out  1  valid with write_done: 1 = SLVERR
read  in  1  GP read request, held until read_done
read_addrs  in  GP_ADDR_WIDTH  GP read byte address
read_data  out  DATA_WIDTH  registered read data, valid with read_done, held after
read_done  out  1  one-cycle pulse: read finished
read_error  out  1  valid with read_done
mem_req  out  1  backend access request, held until mem_ack or timeout
mem_we  out  1  1 = write access
mem_addr  out  GP_ADDR_WIDTH-ADDR_LSB  word index = addrs[GP_ADDR_WIDTH-1:ADDR_LSB]
mem_wdata  out  DATA_WIDTH  write data
mem_wstrb  out  DATA_WIDTH/8  byte enables
mem_ack  in  1  backend completion; may be asserted in the first mem_req cycle
mem_rdata  in  DATA_WIDTH  valid with mem_ack on reads
mem_err  in  1  backend error, valid with mem_ack
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE. mem_req, mem_we, write_done, write_error, read_done, read_error and busy are 0. mem_addr, mem_wdata, mem_wstrb and read_data are 0. rr pointer favours write.
- States: IDLE, ACCESS, DONE.
- IDLE: with neither request pending, stay. With one request, grant it. With both, grant the side not served last; the pointer flips after each grant. Address, data and strobe are captured into registers at the grant.
- Grant with word index >= MEM_DEPTH: go to DONE with error=1. No backend access.
- Grant of a write with strobe==0: go to DONE with error=0. No backend access.
- Any other grant: go to ACCESS. mem_req=1 from the next cycle, with registered mem_we, addr, wdata and wstrb stable until the access ends.
- ACCESS: mem_ack=1 latches mem_err, and mem_rdata on reads, then goes to DONE; mem_req falls the same edge. Timeout counter counts ACCESS cycles. If it reaches TIMEOUT_CYCLES with no ack, go to DONE with error=1; read_data is left unchanged.
- Ack in the same cycle as timeout: the ack wins.
- DONE: assert exactly one of write_done/read_done for one cycle, with its error bit, then return to IDLE. A request seen in IDLE after DONE is a new transaction.
- Latency with zero-wait backend: request in IDLE at cycle N, mem_req at N+1 (ack same cycle), done at N+2, IDLE at N+3. Throughput is 1 access per 3 cycles.
- Requests are sampled only in IDLE. A request that drops mid-access does not cancel it; done still pulses.
- Error bits are 0 whenever the corresponding done is 0.
- Reset asserted mid-ACCESS: mem_req drops immediately (async) and no done is issued.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1); cleared on entry to ACCESS.

Decomposition:
- gp_arb_pkg: state encoding (IDLE/ACCESS/DONE), GRANT_WR/GRANT_RD constants, ADDR_LSB and counter-width helper functions.
- Sub-module gp_rr_arbiter2: 2-request round-robin grant with a pointer register. Inputs: req_wr, req_rd, advance. Outputs: grant_wr, grant_rd.

Test Plan:
1. Write 0x0000_0004 data 0xDEADBEEF strb 0xF, backend acks first cycle → mem_req/mem_we at N+1 with mem_addr=1; write_done=1, write_error=0 at N+2; done pulses once.
2. Read 0x08 with mem_rdata=0x12345678 acked after 3 wait cycles → read_done 1 cycle after ack; read_data=0x12345678 and held afterwards; read_error=0.
3. Write and read asserted together from reset, repeated 4 times → grant order W,R,W,R; each done pulses once per transaction; no overlap of mem_req.
4. Read address 0x3C (word 15, valid) vs 0x40 with GP_ADDR_WIDTH=7 (word 16) → first accesses backend; second gets read_done+read_error=1 with no mem_req.
5. TIMEOUT_CYCLES=4, backend never acks → mem_req high exactly 4 cycles, then write_done+write_error=1; separately, ack in the 4th cycle with mem_err=0 → error=0.
6. Write strb=0 → write_done, error=0, no mem_req. s_axi_aresetn pulsed low mid-ACCESS → mem_req, busy and done go 0 immediately; after release, a pending read is granted normally.
